dmem_stage: RTL and testbench

DMEM_STAGE -- requirements
Module: dmem_stage

---
 rtl/y86_pkg.sv | 30 +++
 rtl/dmem_ram.sv | 41 ++++
 rtl/dmem_stage.sv | 159 +++++++++++++++
 tb/tb_dmem_stage.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86 icode constants, memory-stage state enum and access decode helpers
// Contents:
//   IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ : 4-bit instruction codes
//   dmem_state_e                                 : IDLE / ACCESS / RESP
//   is_write_icode / is_read_icode               : memory access classification

package y86_pkg;

    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dmem_state_e;

    function automatic logic is_write_icode(input logic [3:0] ic);
        return (ic == IRMMOVQ) || (ic == ICALL) || (ic == IPUSHQ);
    endfunction

    function automatic logic is_read_icode(input logic [3:0] ic);
        return (ic == IMRMOVQ) || (ic == IRET) || (ic == IPOPQ);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - byte-array data memory with one word-wide big-endian port
// Ports:
//   clk   : write clock
//   we    : write enable, whole word written on the rising edge
//   addr  : byte address of the most significant byte of the word
//   wdata : write word, MSB byte lands at addr
//   rdata : combinational read word, byte at addr in the MSB position

module dmem_ram #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int BYTES = DATA_W / 8;

    // Contents are deliberately not reset.
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BYTES; i++) begin
                mem[addr + ADDR_W'(i)] <= wdata[DATA_W-1-8*i -: 8];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < BYTES; i++) begin
            rdata[DATA_W-1-8*i -: 8] = mem[addr + ADDR_W'(i)];
        end
    end

endmodule

// File: rtl/dmem_stage.sv
// rtl/dmem_stage.sv - Y86 memory stage: request/response wrapper around dmem_ram with bounds checking
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   req_valid / req_ready  : request handshake (ready only in IDLE)
//   icode, valA/valE/valP  : instruction code and operands, latched on accept
//   resp_valid / resp_ready: response handshake
//   valM, dmem_error       : read data and address fault of the current response
// Optional build macro DMEM_ALIGN_CHECK_EN: also fault word accesses that are not word aligned.

module dmem_stage
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        icode,
    input  logic [DATA_W-1:0] valA,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valP,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] valM,
    output logic              dmem_error
);

    localparam int BYTES = DATA_W / 8;
    // Highest legal start address of a whole word; compared on the full
    // operand width so huge addresses never alias into the array.
    localparam logic [DATA_W-1:0] LAST_ADDR = DATA_W'(DEPTH - BYTES);
    localparam logic [DATA_W-1:0] BYTES_W   = DATA_W'(BYTES);

    dmem_state_e       state_q, state_d;
    logic [3:0]        icode_q, icode_d;
    logic [DATA_W-1:0] val_a_q, val_a_d;
    logic [DATA_W-1:0] val_e_q, val_e_d;
    logic [DATA_W-1:0] val_p_q, val_p_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] valm_q, valm_d;
    logic              err_q, err_d;

    logic              is_wr;
    logic              is_rd;
    logic              misaligned;
    logic              fault;
    logic              ram_we;
    logic [DATA_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic [DATA_W-1:0] ram_rdata;

    // Access decode from the latched request only.
    always_comb begin
        is_wr    = is_write_icode(icode_q);
        is_rd    = is_read_icode(icode_q);
        acc_addr = ((icode_q == IRET) || (icode_q == IPOPQ)) ? val_a_q : val_e_q;
        acc_data = (icode_q == ICALL) ? val_p_q : val_a_q;
`ifdef DMEM_ALIGN_CHECK_EN
        misaligned = (acc_addr % BYTES_W) != '0;
`else
        misaligned = 1'b0;
`endif
        fault  = (is_wr || is_rd) && ((acc_addr > LAST_ADDR) || misaligned);
        // Gating with rst keeps a reset coincident with the ACCESS edge from writing.
        ram_we = (state_q == ACCESS) && is_wr && !fault && !rst;
    end

    dmem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (acc_addr[ADDR_W-1:0]),
        .wdata (acc_data),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d      = state_q;
        icode_d      = icode_q;
        val_a_d      = val_a_q;
        val_e_d      = val_e_q;
        val_p_d      = val_p_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        valm_d       = valm_q;
        err_d        = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    icode_d     = icode;
                    val_a_d     = valA;
                    val_e_d     = valE;
                    val_p_d     = valP;
                    req_ready_d = 1'b0;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                valm_d       = (is_rd && !fault) ? ram_rdata : '0;
                err_d        = fault;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    valm_d       = '0;
                    err_d        = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
                valm_d       = '0;
                err_d        = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            icode_q      <= '0;
            val_a_q      <= '0;
            val_e_q      <= '0;
            val_p_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            valm_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            icode_q      <= icode_d;
            val_a_q      <= val_a_d;
            val_e_q      <= val_e_d;
            val_p_q      <= val_p_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            valm_q       <= valm_d;
            err_q        <= err_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign valM       = valm_q;
    assign dmem_error = err_q;

endmodule

// File: tb/tb_dmem_stage.sv
// tb/tb_dmem_stage.sv - randomized self-checking bench for dmem_stage against a byte-array reference model

module tb_dmem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  icode;
    logic [63:0] valA, valE, valP;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] valM;
    logic        dmem_error;

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl   [4096];
    bit         known [4096];

    dmem_stage dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .icode      (icode),
        .valA       (valA),
        .valE       (valE),
        .valP       (valP),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .valM       (valM),
        .dmem_error (dmem_error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference: which operand is the address, what is stored, and what a read returns.
    function automatic void model_eval(input logic [3:0] ic, input logic [63:0] a, e, p,
                                       output logic [63:0] v, output logic er, output bit kn,
                                       output bit wr_ok, output logic [63:0] addr,
                                       output logic [63:0] data);
        bit wr, rd, flt;
        wr    = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
        rd    = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
        addr  = (ic == 4'h9 || ic == 4'hB) ? a : e;
        data  = (ic == 4'h8) ? p : a;
        flt   = (wr || rd) && (addr > 64'd4088);
`ifdef DMEM_ALIGN_CHECK_EN
        if ((wr || rd) && (addr % 8 != 0)) flt = 1;
`endif
        v     = 0;
        kn    = 1;
        er    = flt;
        wr_ok = wr && !flt;
        if (rd && !flt) begin
            for (int i = 0; i < 8; i++) begin
                int idx;
                idx = int'(addr[11:0]) + i;
                v   = (v << 8) | 64'(mdl[idx]);
                if (!known[idx]) kn = 0;
            end
        end
    endfunction

    task automatic do_req(input logic [3:0] ic, input logic [63:0] a, e, p,
                          input int hold, input string tag);
        logic [63:0] exp_v, addr, data, held_v;
        logic        exp_e, held_e;
        bit          kn, wr_ok, stable;
        int          n;
        model_eval(ic, a, e, p, exp_v, exp_e, kn, wr_ok, addr, data);
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_timeout: req_ready=%b required 1", tag, req_ready);
        end
        req_valid  = 1;
        icode      = ic;
        valA       = a;
        valE       = e;
        valP       = p;
        resp_ready = 0;
        @(negedge clk);
        // Accepted; garbage on the inputs must be ignored from here on.
        req_valid = 0;
        icode     = 4'($urandom);
        valA      = {$urandom, $urandom};
        valE      = {$urandom, $urandom};
        valP      = {$urandom, $urandom};
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s access_phase: resp_valid=%b req_ready=%b required 0 0",
                     tag, resp_valid, req_ready);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s latency: resp_valid=%b required 1", tag, resp_valid);
        end
        checks++;
        if (dmem_error !== exp_e) begin
            errors++;
            $display("FAIL %s dmem_error: got %b required %b", tag, dmem_error, exp_e);
        end
        if (kn) begin
            checks++;
            if (valM !== exp_v) begin
                errors++;
                $display("FAIL %s valM: got %h required %h", tag, valM, exp_v);
            end
        end
        held_v = valM;
        held_e = dmem_error;
        stable = 1;
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 || valM !== held_v || dmem_error !== held_e)
                stable = 0;
        end
        if (hold > 0) begin
            checks++;
            if (!stable) begin
                errors++;
                $display("FAIL %s backpressure_stable: resp_valid=%b req_ready=%b valM=%h required stable 1 0 %h",
                         tag, resp_valid, req_ready, valM, held_v);
            end
        end
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s handshake: resp_valid=%b req_ready=%b required 0 1",
                     tag, resp_valid, req_ready);
        end
        if (wr_ok) begin
            for (int i = 0; i < 8; i++) begin
                int idx;
                idx        = int'(addr[11:0]) + i;
                mdl[idx]   = 8'(data >> (8 * (7 - i)));
                known[idx] = 1;
            end
        end
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || valM !== 64'd0 || dmem_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: req_ready=%b resp_valid=%b valM=%h err=%b required 1 0 0 0",
                     req_ready, resp_valid, valM, dmem_error);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_rmmov_mrmov;
        do_req(4'h4, 64'h1122334455667788, 64'h100, 64'd0, 0, "rmmovq_100");
        checks++;
        if (dut.u_ram.mem[256] !== 8'h11 || dut.u_ram.mem[263] !== 8'h88) begin
            errors++;
            $display("FAIL big_endian_bytes: mem[100]=%h mem[107]=%h required 11 88",
                     dut.u_ram.mem[256], dut.u_ram.mem[263]);
        end
        do_req(4'h5, 64'd0, 64'h100, 64'd0, 0, "mrmovq_100");
    endtask

    task automatic test_call_ret;
        do_req(4'h8, 64'h5555, 64'h200, 64'hABC, 0, "call_200");
        do_req(4'h9, 64'h200, 64'h7777, 64'd0, 0, "ret_200");
    endtask

    task automatic test_bounds;
        do_req(4'h4, 64'hA5A5_0102_0304_5A5A, 64'hFF8, 64'd0, 0, "rmmovq_ff8");
        do_req(4'h5, 64'd0, 64'hFF8, 64'd0, 0, "mrmovq_ff8");
        do_req(4'h5, 64'd0, 64'hFF9, 64'd0, 0, "mrmovq_ff9");
        do_req(4'h5, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 0, "mrmovq_huge");
        do_req(4'h4, 64'hDEAD_DEAD_DEAD_DEAD, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 0, "rmmovq_huge");
        do_req(4'h5, 64'd0, 64'hFF8, 64'd0, 0, "mrmovq_ff8_intact");
        do_req(4'h1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, "nop_noaccess");
    endtask

    task automatic test_backpressure;
        do_req(4'h5, 64'd0, 64'h100, 64'd0, 5, "hold5");
    endtask

    task automatic test_reset_abort;
        bit quiet;
        do_req(4'h4, 64'hDEAD_BEEF_CAFE_F00D, 64'h40, 64'd0, 0, "prior_40");
        req_valid = 1;
        icode     = 4'hA;
        valA      = 64'h0123_4567_89AB_CDEF;
        valE      = 64'h40;
        valP      = 64'd0;
        @(negedge clk);
        req_valid = 0;
        rst       = 1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: req_ready=%b resp_valid=%b required 1 0", req_ready, resp_valid);
        end
        #1;
        rst   = 0;
        quiet = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL abort_no_response: resp_valid=%b required 0", resp_valid);
        end
        do_req(4'h5, 64'd0, 64'h40, 64'd0, 0, "readback_40");
    endtask

    task automatic test_align;
        do_req(4'h4, 64'h0F1E_2D3C_4B5A_6978, 64'h103, 64'd0, 0, "rmmovq_103");
        do_req(4'h5, 64'd0, 64'h103, 64'd0, 0, "mrmovq_103");
    endtask

    task automatic test_back_to_back;
        int accepts;
        req_valid  = 1;
        icode      = 4'h0;
        valA       = 0;
        valE       = 0;
        valP       = 0;
        resp_ready = 1;
        accepts    = 0;
        for (int c = 0; c < 12; c++) begin
            if (req_ready === 1'b1) accepts++;
            @(negedge clk);
        end
        req_valid = 0;
        repeat (3) @(negedge clk);
        resp_ready = 0;
        checks++;
        if (accepts != 4) begin
            errors++;
            $display("FAIL back_to_back: accepts=%0d in 12 cycles required 4", accepts);
        end
    endtask

    task automatic test_random;
        logic [3:0]  ics [10] = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'h0, 4'h1, 4'h6, 4'hC};
        logic [63:0] addr, data, a, e;
        logic [3:0]  ic;
        int          r;
        for (int t = 0; t < 60; t++) begin
            ic   = ics[$urandom_range(0, 9)];
            r    = $urandom_range(0, 9);
            data = {$urandom, $urandom};
            if (r <= 5)      addr = 64'h300 + 64'(8 * $urandom_range(0, 15));
            else if (r == 6) addr = 64'h300 + 64'($urandom_range(0, 127));
            else if (r == 7) addr = 64'hFF9 + 64'($urandom_range(0, 20));
            else if (r == 8) addr = {$urandom | 32'h1, $urandom};
            else             addr = 64'hFF8;
            if (ic == 4'h9 || ic == 4'hB) begin
                a = addr;
                e = {$urandom, $urandom};
            end else begin
                a = data;
                e = addr;
            end
            do_req(ic, a, e, {$urandom, $urandom}, $urandom_range(0, 2), "random");
        end
    endtask

    initial begin
        rst        = 1;
        req_valid  = 0;
        resp_ready = 0;
        icode      = 0;
        valA       = 0;
        valE       = 0;
        valP       = 0;
        for (int i = 0; i < 4096; i++) begin
            mdl[i]   = 8'h00;
            known[i] = 0;
        end
        test_reset();
        test_rmmov_mrmov();
        test_call_ret();
        test_bounds();
        test_backpressure();
        test_reset_abort();
        test_align();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
